// File: rtl/coin_vend_ctrl.sv
// coin_vend_ctrl
// Vending sequencer for the 2-bit coin acceptor interface. It synchronises the
// coin level, turns each new non-zero level into a single coin event, and
// accumulates credit in half-units. Once the credit covers the price it
// requests a dispense and waits for the acknowledge, aborting to a full refund
// on timeout. It then pays back any surplus one half-unit per pulse.
// Coins offered while a vend or payout is in progress are rejected.
module coin_vend_ctrl #(
  parameter int unsigned PRICE   = 3,   // item price in half-units, 1..12
  parameter int unsigned TIMEOUT = 16,  // cycles to wait for Disp_ack, 2..255
  parameter int unsigned CW      = 4    // credit width, must hold PRICE+1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    D_in,
  input  logic          Disp_ack,
  output logic          Disp_req,
  output logic          Vend_done,
  output logic          Chg_pulse,
  output logic          Rej_pulse,
  output logic          Fault,
  output logic [CW-1:0] Credit,
  output logic          Busy
);

  // Sum width: one guard bit above the credit so the price compare never wraps.
  localparam int unsigned CWX = CW + 1;

  localparam logic [CW-1:0]  PRICE_C  = CW'(PRICE);
  localparam logic [CWX-1:0] PRICE_X  = CWX'(PRICE);
  localparam logic [CW-1:0]  ZERO_C   = CW'(0);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);
  localparam logic [CWX-1:0] ADD_HALF = CWX'(1);
  localparam logic [CWX-1:0] ADD_ONE  = CWX'(2);
  localparam logic [CWX-1:0] ADD_NONE = CWX'(0);
  localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);

  // Coin level coding on D_in.
  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_HALF   = 2'b01;
  localparam logic [1:0] COIN_ONE    = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCUM  = 2'b01,
    ST_VEND   = 2'b10,
    ST_CHANGE = 2'b11
  } state_t;

  // Input synchroniser and history.
  logic [1:0]     s1_r;
  logic [1:0]     s2_r;
  logic [1:0]     s3_r;

  // Controller state and registered outputs.
  state_t         state_r;
  logic [7:0]     tmo_cnt_r;
  logic [CW-1:0]  credit_r;
  logic           disp_req_r;
  logic           vend_done_r;
  logic           chg_pulse_r;
  logic           rej_pulse_r;
  logic           fault_r;
  logic           busy_r;

  // Decoded coin event and arithmetic.
  logic [1:0]     coin_ev_s;
  logic           is_coin_s;
  logic           is_cancel_s;
  logic [CWX-1:0] add_s;
  logic [CWX-1:0] sum_s;
  logic           reach_price_s;
  logic [CW-1:0]  remain_s;
  logic           last_chg_s;

  // Two-flop synchroniser for the asynchronous coin level plus a history flop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_r <= COIN_NONE;
      s2_r <= COIN_NONE;
      s3_r <= COIN_NONE;
    end else begin
      s1_r <= D_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // A coin event fires once on the first cycle a non-zero level is seen.
  always_comb begin
    coin_ev_s = COIN_NONE;
    if ((s2_r != COIN_NONE) && (s3_r == COIN_NONE)) begin
      coin_ev_s = s2_r;
    end else begin
      coin_ev_s = COIN_NONE;
    end
  end

  // Classify the event and translate coins into a credit increment.
  always_comb begin
    add_s       = ADD_NONE;
    is_coin_s   = 1'b0;
    is_cancel_s = 1'b0;
    case (coin_ev_s)
      COIN_HALF: begin
        add_s     = ADD_HALF;
        is_coin_s = 1'b1;
      end
      COIN_ONE: begin
        add_s     = ADD_ONE;
        is_coin_s = 1'b1;
      end
      COIN_CANCEL: begin
        is_cancel_s = 1'b1;
      end
      default: begin
        add_s       = ADD_NONE;
        is_coin_s   = 1'b0;
        is_cancel_s = 1'b0;
      end
    endcase
  end

  // Credit arithmetic shared by the accumulate, vend and payout paths.
  always_comb begin
    sum_s         = {1'b0, credit_r} + add_s;
    reach_price_s = (sum_s >= PRICE_X);
    remain_s      = credit_r - PRICE_C;
    last_chg_s    = (credit_r == ONE_C);
  end

  // Main controller: state, credit, timeout counter and all registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      tmo_cnt_r   <= 8'd0;
      credit_r    <= ZERO_C;
      disp_req_r  <= 1'b0;
      vend_done_r <= 1'b0;
      chg_pulse_r <= 1'b0;
      rej_pulse_r <= 1'b0;
      fault_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to zero unless re-armed below.
      vend_done_r <= 1'b0;
      rej_pulse_r <= 1'b0;
      fault_r     <= 1'b0;

      case (state_r)
        ST_IDLE, ST_ACCUM: begin
          chg_pulse_r <= 1'b0;
          if (is_cancel_s) begin
            // Cancel with nothing inserted is a no-op.
            if (credit_r != ZERO_C) begin
              state_r     <= ST_CHANGE;
              chg_pulse_r <= 1'b1;
              busy_r      <= 1'b1;
            end
          end else if (is_coin_s) begin
            credit_r <= sum_s[CW-1:0];
            // Move to VEND on the adding edge so credit tops out at PRICE+1.
            if (reach_price_s) begin
              state_r    <= ST_VEND;
              disp_req_r <= 1'b1;
              busy_r     <= 1'b1;
              tmo_cnt_r  <= 8'd0;
            end else begin
              state_r <= ST_ACCUM;
            end
          end
        end

        ST_VEND: begin
          rej_pulse_r <= is_coin_s;
          if (Disp_ack) begin
            // Acknowledge wins over a coincident timeout.
            vend_done_r <= 1'b1;
            disp_req_r  <= 1'b0;
            credit_r    <= remain_s;
            if (remain_s != ZERO_C) begin
              state_r     <= ST_CHANGE;
              chg_pulse_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            // Dispenser never answered: refund the whole credit.
            fault_r     <= 1'b1;
            disp_req_r  <= 1'b0;
            state_r     <= ST_CHANGE;
            chg_pulse_r <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end

        ST_CHANGE: begin
          rej_pulse_r <= is_coin_s;
          // Pulse high one cycle, low the next; credit drops as each pulse ends.
          if (chg_pulse_r) begin
            chg_pulse_r <= 1'b0;
            credit_r    <= credit_r - ONE_C;
            if (last_chg_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            chg_pulse_r <= 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean idle controller.
          state_r     <= ST_IDLE;
          tmo_cnt_r   <= 8'd0;
          credit_r    <= ZERO_C;
          disp_req_r  <= 1'b0;
          chg_pulse_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign Disp_req  = disp_req_r;
  assign Vend_done = vend_done_r;
  assign Chg_pulse = chg_pulse_r;
  assign Rej_pulse = rej_pulse_r;
  assign Fault     = fault_r;
  assign Credit    = credit_r;
  assign Busy      = busy_r;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Scoreboard bench for coin_vend_ctrl (PRICE=3, TIMEOUT=16, CW=4).
// Each directed scenario pushes the hand-computed sequence of output vectors
// it should produce, together with the cycle distance from the previous
// output change. A monitor samples the outputs on every falling edge and pops
// one expectation for every change it sees.
module tb_coin_vend_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] D_in;
  logic       Disp_ack;
  logic       Disp_req;
  logic       Vend_done;
  logic       Chg_pulse;
  logic       Rej_pulse;
  logic       Fault;
  logic [3:0] Credit;
  logic       Busy;

  coin_vend_ctrl #(
    .PRICE   (3),
    .TIMEOUT (16),
    .CW      (4)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .D_in      (D_in),
    .Disp_ack  (Disp_ack),
    .Disp_req  (Disp_req),
    .Vend_done (Vend_done),
    .Chg_pulse (Chg_pulse),
    .Rej_pulse (Rej_pulse),
    .Fault     (Fault),
    .Credit    (Credit),
    .Busy      (Busy)
  );

  // 32 ns clock period.
  always #16 Clk = ~Clk;

  typedef struct {
    string      tag;
    logic [9:0] vec;
    int         gap;   // cycles since previous change, -1 = don't care
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc_cnt = 0;
  int         last_chg_cyc = 0;
  logic [9:0] prev_vec = 10'b0;
  logic [9:0] out_vec;

  assign out_vec = {Disp_req, Vend_done, Chg_pulse, Rej_pulse, Fault, Busy, Credit};

  // Rising-edge counter used to time output changes.
  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every change of the output vector must match the next expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (out_vec !== prev_vec) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_change: got %b, required no change from %b at cycle %0d",
                 out_vec, prev_vec, cyc_cnt);
      end else begin
        e = sb_q.pop_front();
        n_chk++;
        if (out_vec !== e.vec) begin
          n_fail++;
          $display("FAIL %s: outputs got %b required %b (cycle %0d)", e.tag, out_vec, e.vec, cyc_cnt);
        end
        if (e.gap >= 0) begin
          n_chk++;
          if ((cyc_cnt - last_chg_cyc) != e.gap) begin
            n_fail++;
            $display("FAIL %s_timing: gap got %0d cycles required %0d", e.tag,
                     cyc_cnt - last_chg_cyc, e.gap);
          end
        end
      end
      last_chg_cyc = cyc_cnt;
      prev_vec     = out_vec;
    end
  end

  function automatic logic [9:0] ov(logic req, logic done, logic chg, logic rej,
                                    logic flt, logic busy, int cr);
    logic [3:0] c;
    c = cr[3:0];
    return {req, done, chg, rej, flt, busy, c};
  endfunction

  task automatic exp_push(string tag, logic [9:0] v, int g);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    e.gap = g;
    sb_q.push_back(e);
  endtask

  // Advance n cycles; inputs are always changed 8 ns after a rising edge.
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge Clk);
      #8;
    end
  endtask

  task automatic step(logic [1:0] d, logic a, int n);
    D_in     = d;
    Disp_ack = a;
    cyc(n);
  endtask

  task automatic chk(string tag, logic [9:0] got, logic [9:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", tag, got, req);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    D_in     = 2'b00;
    Disp_ack = 1'b0;
    repeat (2) @(posedge Clk);
    #8;
    chk("reset_state", out_vec, 10'b0);
    Reset = 1'b0;
    cyc(3);

    // 1: three half-unit coins, exact price, no change.
    exp_push("t1_credit1", ov(0, 0, 0, 0, 0, 0, 1), -1);
    exp_push("t1_credit2", ov(0, 0, 0, 0, 0, 0, 2), 2);
    exp_push("t1_vend",    ov(1, 0, 0, 0, 0, 1, 3), 2);
    exp_push("t1_done",    ov(0, 1, 0, 0, 0, 0, 0), 3);
    exp_push("t1_idle",    ov(0, 0, 0, 0, 0, 0, 0), 1);
    step(2'b01, 1'b0, 1); step(2'b00, 1'b0, 1);
    step(2'b01, 1'b0, 1); step(2'b00, 1'b0, 1);
    step(2'b01, 1'b0, 1); step(2'b00, 1'b0, 4);
    step(2'b00, 1'b1, 1); step(2'b00, 1'b0, 6);

    // 2: two one-unit coins overshoot to 4, one change pulse.
    exp_push("t2_credit2",   ov(0, 0, 0, 0, 0, 0, 2), -1);
    exp_push("t2_vend",      ov(1, 0, 0, 0, 0, 1, 4), 2);
    exp_push("t2_done_chg",  ov(0, 1, 1, 0, 0, 1, 1), 1);
    exp_push("t2_idle",      ov(0, 0, 0, 0, 0, 0, 0), 1);
    step(2'b10, 1'b0, 1); step(2'b00, 1'b0, 1);
    step(2'b10, 1'b0, 1); step(2'b00, 1'b0, 2);
    step(2'b00, 1'b1, 1); step(2'b00, 1'b0, 6);

    // 3: held coin counts once, cancel refunds it.
    exp_push("t3_credit1", ov(0, 0, 0, 0, 0, 0, 1), -1);
    exp_push("t3_cancel",  ov(0, 0, 1, 0, 0, 1, 1), 5);
    exp_push("t3_idle",    ov(0, 0, 0, 0, 0, 0, 0), 1);
    step(2'b01, 1'b0, 4); step(2'b00, 1'b0, 1);
    step(2'b11, 1'b0, 1); step(2'b00, 1'b0, 6);

    // 4: no acknowledge, timeout after 16 cycles, full refund of 3.
    exp_push("t4_credit2", ov(0, 0, 0, 0, 0, 0, 2), -1);
    exp_push("t4_vend",    ov(1, 0, 0, 0, 0, 1, 3), 2);
    exp_push("t4_fault",   ov(0, 0, 1, 0, 1, 1, 3), 16);
    exp_push("t4_low1",    ov(0, 0, 0, 0, 0, 1, 2), 1);
    exp_push("t4_chg2",    ov(0, 0, 1, 0, 0, 1, 2), 1);
    exp_push("t4_low2",    ov(0, 0, 0, 0, 0, 1, 1), 1);
    exp_push("t4_chg3",    ov(0, 0, 1, 0, 0, 1, 1), 1);
    exp_push("t4_idle",    ov(0, 0, 0, 0, 0, 0, 0), 1);
    step(2'b10, 1'b0, 1); step(2'b00, 1'b0, 1);
    step(2'b01, 1'b0, 1); step(2'b00, 1'b0, 30);

    // 5: coin during VEND is rejected, cancel during VEND ignored.
    exp_push("t5_credit1", ov(0, 0, 0, 0, 0, 0, 1), -1);
    exp_push("t5_vend",    ov(1, 0, 0, 0, 0, 1, 3), 2);
    exp_push("t5_rej",     ov(1, 0, 0, 1, 0, 1, 3), 3);
    exp_push("t5_rej_end", ov(1, 0, 0, 0, 0, 1, 3), 1);
    exp_push("t5_done",    ov(0, 1, 0, 0, 0, 0, 0), 4);
    exp_push("t5_idle",    ov(0, 0, 0, 0, 0, 0, 0), 1);
    step(2'b01, 1'b0, 1); step(2'b00, 1'b0, 1);
    step(2'b10, 1'b0, 1); step(2'b00, 1'b0, 2);
    step(2'b01, 1'b0, 1); step(2'b00, 1'b0, 1);
    step(2'b11, 1'b0, 1); step(2'b00, 1'b0, 4);
    step(2'b00, 1'b1, 1); step(2'b00, 1'b0, 6);

    // 6: reset during CHANGE with credit 2 clears everything at once.
    exp_push("t6_credit2", ov(0, 0, 0, 0, 0, 0, 2), -1);
    exp_push("t6_cancel",  ov(0, 0, 1, 0, 0, 1, 2), 2);
    exp_push("t6_reset",   ov(0, 0, 0, 0, 0, 0, 0), 1);
    step(2'b10, 1'b0, 1); step(2'b00, 1'b0, 1);
    step(2'b11, 1'b0, 1); step(2'b00, 1'b0, 2);
    #12;
    Reset = 1'b1;
    #4;
    chk("t6_reset_async", out_vec, 10'b0);
    #16;
    Reset = 1'b0;
    cyc(8);
    chk("t6_post_idle", out_vec, 10'b0);

    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expectations required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_vend_ctrl.md
Name: coin_vend_ctrl

Overview:
Vending controller that sequences the 2-bit coin datapath (D_in coding as used by the Ztj state-machine experiments). It synchronises and edge-detects coin inputs and accumulates credit. When credit reaches the price it runs a request/acknowledge handshake with the dispenser, then returns change or refunds one half-unit pulse at a time. It sits between the coin acceptor and the dispenser/change-hopper drivers in the 综合设计 top level.

Parameters:
PRICE, 3, item price in half-units (3 = 1.5 yuan); legal range 1..12
TIMEOUT, 16, cycles to wait for Disp_ack before aborting to refund; legal range 2..255
CW, 4, credit register width; must hold PRICE+1

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
D_in  input  2  coin level: 00 none, 01 half-unit, 10 one-unit, 11 cancel; asynchronous to Clk, held for several cycles
Disp_ack  input  1  dispenser acknowledge, level, synchronous to Clk
Disp_req  output  1  dispense request, held until acknowledged or timed out
Vend_done  output  1  one-cycle pulse when a dispense is acknowledged
Chg_pulse  output  1  one-cycle pulse per half-unit returned
Rej_pulse  output  1  one-cycle pulse when a coin arrives while busy (coin rejected)
Fault  output  1  one-cycle pulse on dispenser timeout
Credit  output  CW  current credit in half-units
Busy  output  1  high in VEND or CHANGE

Behaviour:
- One clock. Reset is asynchronous and active-high. While Reset=1, all registers clear, state=IDLE, and all outputs are 0.
- Input path: D_in passes through 2 flops (s1, s2) plus a history flop s3. A coin event fires in a cycle when s2!=00 and s3==00, so a held level counts once. The event value is s2.
- Latency: a new D_in level sampled at edge k takes effect on the state/credit at edge k+2.
- States are IDLE, ACCUM, VEND and CHANGE. IDLE means credit=0.
- IDLE/ACCUM, event 01: credit+=1. Event 10: credit+=2. Then go to ACCUM.
- IDLE/ACCUM, after the add: if credit>=PRICE, go to VEND on the same edge.
- IDLE/ACCUM, event 11 (cancel): if credit>0 go to CHANGE; if credit=0 ignore it.
- Credit never exceeds PRICE+1, because the transition to VEND happens on the adding edge. No saturation logic is needed beyond that.
- VEND: Disp_req=1 combinationally from state.
- VEND, Disp_ack=1 sampled on an edge: Vend_done pulses the following cycle and credit-=PRICE on that edge. Next state is CHANGE if the remainder>0, else IDLE. Disp_req drops in the cycle after ack is sampled.
- VEND timeout counter: starts at 0 on entry to VEND and increments each cycle. If it reaches TIMEOUT with no ack, Fault pulses, Disp_req drops, and the state goes to CHANGE with credit unchanged (full refund). Ack on the same edge as the timeout takes priority, and no Fault is raised.
- CHANGE: Chg_pulse is asserted on alternate cycles: first pulse in the first cycle in CHANGE, then low for one cycle. Each pulse decrements credit by 1. After the pulse that brings credit to 0, go to IDLE.
- Coin events (01/10) in VEND or CHANGE: Rej_pulse for one cycle, credit unchanged. Event 11 in VEND/CHANGE is ignored.
- Busy = (state==VEND or CHANGE).
- Credit is a registered output.
- Reset mid-operation (any state) clears credit immediately. No change is paid out.

Test Plan:
1. Clk period 32 ns, PRICE=3. D_in 01,00,01,00,01,00 each held 25 ns → Credit steps 1,2,3. Disp_req rises 2 edges after the third 01 is sampled. Disp_ack raised 3 cycles later → Vend_done one pulse, Credit=0, zero Chg_pulse, state IDLE.
2. D_in 10,00,10 → Credit 2 then 4 → VEND. Ack → Credit=1, exactly one Chg_pulse, then Credit=0 and Busy=0.
3. D_in 01 held for 4 cycles, then 00, then 11 → Credit=1 (counted once), then CHANGE with one Chg_pulse. Disp_req never asserts.
4. Reach VEND with credit 3 and hold Disp_ack=0 → Fault pulses exactly 16 cycles after entering VEND. Disp_req then drops, and 3 Chg_pulses follow on alternate cycles. No Vend_done.
5. During VEND apply D_in 01 then 00 → one Rej_pulse, Credit unchanged. Apply 11 → no effect.
6. Assert Reset for 20 ns in CHANGE with Credit=2 → within the same cycle all outputs are 0 and Credit=0. After release, the state is IDLE and no further Chg_pulse occurs.
